// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin owner of a register bank write port
// for two requesters, with a registered read-back path.
module reg_write_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_a,
  input  logic [ADDR_W-1:0]      addr_a,
  input  logic [31:0]            data_a,
  output logic                   ack_a,
  output logic                   err_a,
  input  logic                   req_b,
  input  logic [ADDR_W-1:0]      addr_b,
  input  logic [31:0]            data_b,
  output logic                   ack_b,
  output logic                   err_b,
  output logic [NUM_REGS-1:0]    reg_write,
  output logic [31:0]            reg_d,
  input  logic [32*NUM_REGS-1:0] reg_q,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [31:0]            rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RESP
  } state_t;

  localparam logic [ADDR_W:0] NR =
    (ADDR_W+1)'(NUM_REGS);

  state_t              state;
  logic                owner;
  logic                last_grant;
  logic                lat_err;

  logic                pick_b;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_data;
  logic                sel_ok;
  logic [NUM_REGS-1:0] sel_hot;
  logic [31:0]         rd_mux;

  // choose the winner; last_grant=1 means B went last
  always_comb begin
    pick_b   = req_b & (~req_a | ~last_grant);
    sel_addr = pick_b ? addr_b : addr_a;
    sel_data = pick_b ? data_b : data_a;
    sel_ok   = {1'b0, sel_addr} < NR;
    sel_hot  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_addr == ADDR_W'(i)) begin
        sel_hot[i] = 1'b1;
      end
    end
  end

  // grant, strobe and respond with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lat_err    <= 1'b0;
      reg_write  <= '0;
      reg_d      <= '0;
      ack_a      <= 1'b0;
      err_a      <= 1'b0;
      ack_b      <= 1'b0;
      err_b      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_a | req_b) begin
            owner      <= pick_b;
            last_grant <= pick_b;
            lat_err    <= ~sel_ok;
            reg_write  <= sel_hot;
            reg_d      <= sel_data;
            state      <= WRITE;
          end
        end
        WRITE: begin
          reg_write <= '0;
          ack_a     <= ~owner & ~lat_err;
          err_a     <= ~owner &  lat_err;
          ack_b     <=  owner & ~lat_err;
          err_b     <=  owner &  lat_err;
          state     <= RESP;
        end
        RESP: begin
          ack_a <= 1'b0;
          err_a <= 1'b0;
          ack_b <= 1'b0;
          err_b <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // select the read-back slice; unmapped addresses read zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_mux = reg_q[32*i +: 32];
      end
    end
  end

  // register the read-back data every cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed plus random checks of the
// write arbiter against a transaction-level reference model.
module tb_reg_write_arbiter;

  localparam int NR = 6;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_a, req_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [31:0]   data_a, data_b;
  logic          ack_a, err_a, ack_b, err_b;
  logic [NR-1:0] reg_write;
  logic [31:0]   reg_d;
  logic [32*NR-1:0] reg_q;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  logic [31:0] bank [NR] = '{default: 32'h0};

  int total = 0;
  int bad   = 0;

  logic        m_last;
  logic [31:0] ref_mem [8];

  reg_write_arbiter #(
    .NUM_REGS(NR),
    .ADDR_W  (AW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_a    (req_a),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .ack_a    (ack_a),
    .err_a    (err_a),
    .req_b    (req_b),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .ack_b    (ack_b),
    .err_b    (err_b),
    .reg_write(reg_write),
    .reg_d    (reg_d),
    .reg_q    (reg_q),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    for (int i = 0; i < NR; i++) begin
      if (reg_write[i]) bank[i] <= reg_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      reg_q[32*i +: 32] = bank[i];
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] resp_now();
    return {ack_a, err_a, ack_b, err_b};
  endfunction

  task automatic run_txn(input string tag);
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          ok;
    logic [NR-1:0] hot;
    logic [3:0]    rsp;
    if (!req_a && !req_b) begin
      tick;
      chk({tag, ".idle_strobe"}, 64'(reg_write), 64'd0);
      chk({tag, ".idle_resp"}, 64'(resp_now()), 64'd0);
    end else begin
      w   = (req_a && req_b) ? ~m_last : req_b;
      a   = w ? addr_b : addr_a;
      d   = w ? data_b : data_a;
      ok  = int'(a) < NR;
      hot = ok ? (NR'(1) << a) : '0;
      if (w) rsp = ok ? 4'b0010 : 4'b0001;
      else   rsp = ok ? 4'b1000 : 4'b0100;
      tick;
      chk({tag, ".strobe"}, 64'(reg_write), 64'(hot));
      if (ok) chk({tag, ".reg_d"}, 64'(reg_d), 64'(d));
      chk({tag, ".resp_early"}, 64'(resp_now()), 64'd0);
      tick;
      chk({tag, ".resp"}, 64'(resp_now()), 64'(rsp));
      chk({tag, ".strobe_off"}, 64'(reg_write), 64'd0);
      tick;
      chk({tag, ".resp_clear"}, 64'(resp_now()), 64'd0);
      m_last = w;
      if (ok) ref_mem[a] = d;
    end
  endtask

  task automatic check_rd(input string tag, input logic [AW-1:0] a);
    rd_addr = a;
    tick;
    chk(tag, 64'(rd_data), 64'(ref_mem[a]));
  endtask

  initial begin
    logic [31:0] old;
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
    req_a = 0; req_b = 0;
    addr_a = 0; addr_b = 0;
    data_a = 0; data_b = 0;
    rd_addr = 0;
    reset = 1;
    tick;
    tick;
    reset = 0;
    m_last = 1'b1;

    for (int c = 0; c < 5; c++) begin
      tick;
      chk("reset_idle", 64'({reg_write, resp_now()}), 64'd0);
      chk("reset_reg_d", 64'(reg_d), 64'd0);
      chk("reset_rd", 64'(rd_data), 64'd0);
    end

    req_a = 1; addr_a = 3; data_a = 32'hDEADBEEF;
    run_txn("single");
    req_a = 0;
    check_rd("single_rd", 3);

    reset = 1;
    tick;
    reset = 0;
    m_last = 1'b1;
    req_a = 1; addr_a = 1; data_a = 32'h1111_1111;
    req_b = 1; addr_b = 2; data_b = 32'h2222_2222;
    for (int n = 0; n < 4; n++) run_txn("contend");
    req_a = 0; req_b = 0;
    check_rd("contend_rd1", 1);
    check_rd("contend_rd2", 2);

    req_b = 1; addr_b = 7; data_b = 32'hBAD0_0007;
    run_txn("oor7");
    addr_b = 6; data_b = 32'hBAD0_0006;
    run_txn("oor6");
    req_b = 0;
    check_rd("oor_rd7", 7);
    check_rd("oor_rd6", 6);
    for (int i = 0; i < NR; i++) check_rd("bank_keep", AW'(i));

    req_a = 1; addr_a = 5; data_a = 32'h5555_AAAA;
    tick;
    chk("midop.strobe", 64'(reg_write), 64'(NR'(1) << 5));
    ref_mem[5] = data_a;
    reset = 1;
    tick;
    chk("midop.strobe_off", 64'(reg_write), 64'd0);
    chk("midop.resp", 64'(resp_now()), 64'd0);
    reset = 0;
    m_last = 1'b1;
    data_a = 32'h5A5A_0005;
    run_txn("after_reset");
    req_a = 0;
    check_rd("after_reset_rd", 5);

    rd_addr = 4;
    old = ref_mem[4];
    req_a = 1; addr_a = 4; data_a = 32'hCAFEF00D;
    tick;
    chk("ovl.strobe", 64'(reg_write), 64'(NR'(1) << 4));
    tick;
    chk("ovl.rd_old", 64'(rd_data), 64'(old));
    chk("ovl.ack", 64'(resp_now()), 64'b1000);
    tick;
    chk("ovl.rd_new", 64'(rd_data), 64'h0000_0000_CAFE_F00D);
    req_a = 0;
    m_last = 1'b0;
    ref_mem[4] = 32'hCAFEF00D;

    for (int n = 0; n < 40; n++) begin
      req_a  = 1'($urandom_range(0, 1));
      req_b  = 1'($urandom_range(0, 1));
      addr_a = AW'($urandom_range(0, 7));
      addr_b = AW'($urandom_range(0, 7));
      data_a = $urandom;
      data_b = $urandom;
      run_txn("rand");
      req_a = 0; req_b = 0;
      check_rd("rand_rd", AW'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
